// File: rtl/rob_commit.sv
// Reorder-buffer commit stage: allocates entries in program order, collects
// out-of-order completions and retires at most one done head entry per cycle
// onto a registered architectural register-file write port.
module rob_commit #(
   parameter int unsigned DEPTH = 8,
   parameter int unsigned XLEN  = 32
) (
   input  logic                       clk,
   input  logic                       rst,
   // Dispatch / allocation
   input  logic                       i_alloc_valid,
   input  logic [4:0]                 i_alloc_rd,
   output logic                       o_alloc_ready,
   output logic [$clog2(DEPTH)-1:0]   o_alloc_tag,
   // Execution completion
   input  logic                       i_cmpl_valid,
   input  logic [$clog2(DEPTH)-1:0]   i_cmpl_tag,
   input  logic [XLEN-1:0]            i_cmpl_data,
   // Pipeline flush
   input  logic                       i_flush,
   // Register-file write port
   output logic                       o_wr,
   output logic [4:0]                 o_rd,
   output logic [XLEN-1:0]            o_write_data,
   // Occupancy
   output logic [$clog2(DEPTH):0]     o_count,
   output logic                       o_empty,
   output logic                       o_full
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam logic [AW:0]   CountFull = (AW + 1)'(DEPTH);
   localparam logic [AW-1:0] IdxMax    = AW'(DEPTH - 1);

   // Per-entry state
   logic [DEPTH-1:0] valid_q, valid_d;
   logic [DEPTH-1:0] done_q, done_d;
   logic [4:0]       rd_q   [DEPTH];
   logic [4:0]       rd_d   [DEPTH];
   logic [XLEN-1:0]  data_q [DEPTH];
   logic [XLEN-1:0]  data_d [DEPTH];

   // Circular pointers; the wrap bits disambiguate full from empty
   logic [AW-1:0] head_q, head_d;
   logic [AW-1:0] tail_q, tail_d;
   logic          head_wrap_q, head_wrap_d;
   logic          tail_wrap_q, tail_wrap_d;

   // Registered write port
   logic            wr_q, wr_d;
   logic [4:0]      wr_rd_q, wr_rd_d;
   logic [XLEN-1:0] wr_data_q, wr_data_d;

   logic [AW:0] count;
   logic        full;
   logic        alloc_fire;
   logic        cmpl_fire;
   logic        commit;

   // Occupancy is the wrap-extended pointer distance, so it spans 0..DEPTH
   assign count      = {tail_wrap_q, tail_q} - {head_wrap_q, head_q};
   assign full       = (count == CountFull);
   // Ready comes only from registered state: a same-cycle commit does not free a slot
   assign alloc_fire = i_alloc_valid && !full;
   assign cmpl_fire  = i_cmpl_valid && valid_q[i_cmpl_tag] && !done_q[i_cmpl_tag];
   assign commit     = valid_q[head_q] && done_q[head_q];

   // Next-state for entries, pointers and the write port; flush wins over everything
   always_comb begin
      valid_d     = valid_q;
      done_d      = done_q;
      rd_d        = rd_q;
      data_d      = data_q;
      head_d      = head_q;
      tail_d      = tail_q;
      head_wrap_d = head_wrap_q;
      tail_wrap_d = tail_wrap_q;
      wr_d        = 1'b0;
      wr_rd_d     = wr_rd_q;
      wr_data_d   = wr_data_q;

      if (i_flush) begin
         valid_d     = '0;
         done_d      = '0;
         head_d      = '0;
         tail_d      = '0;
         head_wrap_d = 1'b0;
         tail_wrap_d = 1'b0;
      end else begin
         // A completion can never hit the committing head (it is already done)
         // nor the allocating tail (it is invalid), so the updates are disjoint.
         if (cmpl_fire) begin
            done_d[i_cmpl_tag] = 1'b1;
            data_d[i_cmpl_tag] = i_cmpl_data;
         end

         if (commit) begin
            valid_d[head_q] = 1'b0;
            done_d[head_q]  = 1'b0;
            // x0 is architecturally hardwired: retire without writing
            wr_d            = (rd_q[head_q] != 5'd0);
            wr_rd_d         = rd_q[head_q];
            wr_data_d       = data_q[head_q];
            head_d          = head_q + 1'b1;
            if (head_q == IdxMax) begin
               head_wrap_d = ~head_wrap_q;
            end
         end

         if (alloc_fire) begin
            valid_d[tail_q] = 1'b1;
            done_d[tail_q]  = 1'b0;
            rd_d[tail_q]    = i_alloc_rd;
            tail_d          = tail_q + 1'b1;
            if (tail_q == IdxMax) begin
               tail_wrap_d = ~tail_wrap_q;
            end
         end
      end
   end

   // State registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q     <= '0;
         done_q      <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            rd_q[i]   <= '0;
            data_q[i] <= '0;
         end
         head_q      <= '0;
         tail_q      <= '0;
         head_wrap_q <= 1'b0;
         tail_wrap_q <= 1'b0;
         wr_q        <= 1'b0;
         wr_rd_q     <= '0;
         wr_data_q   <= '0;
      end else begin
         valid_q     <= valid_d;
         done_q      <= done_d;
         rd_q        <= rd_d;
         data_q      <= data_d;
         head_q      <= head_d;
         tail_q      <= tail_d;
         head_wrap_q <= head_wrap_d;
         tail_wrap_q <= tail_wrap_d;
         wr_q        <= wr_d;
         wr_rd_q     <= wr_rd_d;
         wr_data_q   <= wr_data_d;
      end
   end

   assign o_alloc_ready = !full;
   assign o_alloc_tag   = tail_q;
   assign o_count       = count;
   assign o_empty       = (count == '0);
   assign o_full        = full;
   assign o_wr          = wr_q;
   assign o_rd          = wr_rd_q;
   assign o_write_data  = wr_data_q;

endmodule

// File: tb/tb_rob_commit.sv
// Self-checking bench for rob_commit: expected register writes are queued in
// allocation order as stimulus is driven and popped by a write-port monitor.
module tb_rob_commit;

   localparam int unsigned DEPTH = 8;
   localparam int unsigned XLEN  = 32;
   localparam int unsigned AW    = $clog2(DEPTH);

   logic            clk;
   logic            rst;
   logic            i_alloc_valid;
   logic [4:0]      i_alloc_rd;
   logic            o_alloc_ready;
   logic [AW-1:0]   o_alloc_tag;
   logic            i_cmpl_valid;
   logic [AW-1:0]   i_cmpl_tag;
   logic [XLEN-1:0] i_cmpl_data;
   logic            i_flush;
   logic            o_wr;
   logic [4:0]      o_rd;
   logic [XLEN-1:0] o_write_data;
   logic [AW:0]     o_count;
   logic            o_empty;
   logic            o_full;

   typedef struct {
      logic [4:0]      rd;
      logic [XLEN-1:0] data;
   } exp_t;

   exp_t exp_q[$];
   int   errors = 0;
   int   checks = 0;
   int   wr_pulses = 0;

   rob_commit #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
      .clk           (clk),
      .rst           (rst),
      .i_alloc_valid (i_alloc_valid),
      .i_alloc_rd    (i_alloc_rd),
      .o_alloc_ready (o_alloc_ready),
      .o_alloc_tag   (o_alloc_tag),
      .i_cmpl_valid  (i_cmpl_valid),
      .i_cmpl_tag    (i_cmpl_tag),
      .i_cmpl_data   (i_cmpl_data),
      .i_flush       (i_flush),
      .o_wr          (o_wr),
      .o_rd          (o_rd),
      .o_write_data  (o_write_data),
      .o_count       (o_count),
      .o_empty       (o_empty),
      .o_full        (o_full)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Write-port monitor: every o_wr pulse must match the oldest expected write
   always @(negedge clk) begin
      exp_t e;
      if (o_wr !== 1'b0) begin
         wr_pulses++;
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_write: got wr=%b rd=%0d data=%h, expected no write",
                     o_wr, o_rd, o_write_data);
         end else begin
            e = exp_q.pop_front();
            if (o_rd !== e.rd || o_write_data !== e.data) begin
               errors++;
               $display("FAIL write_order: got rd=%0d data=%h, expected rd=%0d data=%h",
                        o_rd, o_write_data, e.rd, e.data);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [XLEN-1:0] dval(input logic [4:0] rd);
      return 32'h5A00_0000 | {27'd0, rd} | (32'(rd) << 12);
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      i_alloc_valid = 1'b0;
      i_cmpl_valid = 1'b0;
      i_flush = 1'b0;
      exp_q.delete();
      tick();
      rst = 1'b0;
   endtask

   task automatic alloc(input logic [4:0] rd, input logic [XLEN-1:0] data, input int tag);
      i_alloc_valid = 1'b1;
      i_alloc_rd = rd;
      checks++;
      if (o_alloc_tag !== AW'(tag) || o_alloc_ready !== 1'b1) begin
         errors++;
         $display("FAIL alloc_tag: got tag=%0d ready=%b, expected tag=%0d ready=1",
                  o_alloc_tag, o_alloc_ready, tag);
      end
      if (rd != 5'd0) exp_q.push_back('{rd, data});
      tick();
      i_alloc_valid = 1'b0;
   endtask

   task automatic complete(input int tag, input logic [XLEN-1:0] data);
      i_cmpl_valid = 1'b1;
      i_cmpl_tag = AW'(tag);
      i_cmpl_data = data;
      tick();
      i_cmpl_valid = 1'b0;
   endtask

   task automatic wait_drain(input string name);
      int n = 0;
      while ((exp_q.size() != 0 || o_empty !== 1'b1) && n < 60) begin
         tick();
         n++;
      end
      checks++;
      if (exp_q.size() != 0 || o_empty !== 1'b1) begin
         errors++;
         $display("FAIL %s_drain: got pending=%0d empty=%b, expected pending=0 empty=1",
                  name, exp_q.size(), o_empty);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      i_alloc_valid = 1'b0;
      i_alloc_rd = '0;
      i_cmpl_valid = 1'b0;
      i_cmpl_tag = '0;
      i_cmpl_data = '0;
      i_flush = 1'b0;
      tick();
      tick();
      rst = 1'b0;
      checks++;
      if (o_count !== 4'd0 || o_empty !== 1'b1 || o_full !== 1'b0 || o_alloc_ready !== 1'b1
          || o_alloc_tag !== 3'd0) begin
         errors++;
         $display("FAIL reset_occupancy: got count=%0d empty=%b full=%b ready=%b tag=%0d, %s",
                  o_count, o_empty, o_full, o_alloc_ready, o_alloc_tag,
                  "expected 0/1/0/1/0");
      end
      checks++;
      if (o_wr !== 1'b0 || o_rd !== 5'd0 || o_write_data !== 32'd0) begin
         errors++;
         $display("FAIL reset_wport: got wr=%b rd=%0d data=%h, expected 0/0/0",
                  o_wr, o_rd, o_write_data);
      end
   endtask

   task automatic test_single();
      int p;
      do_reset();
      alloc(5'd5, 32'hDEAD_BEEF, 0);
      complete(0, 32'hDEAD_BEEF);
      p = wr_pulses;
      checks++;
      if (o_wr !== 1'b0) begin
         errors++;
         $display("FAIL single_early: got wr=%b, expected 0", o_wr);
      end
      tick();
      checks++;
      if (o_wr !== 1'b1 || o_rd !== 5'd5 || o_write_data !== 32'hDEAD_BEEF) begin
         errors++;
         $display("FAIL single_write: got wr=%b rd=%0d data=%h, expected 1/5/deadbeef",
                  o_wr, o_rd, o_write_data);
      end
      checks++;
      if (o_empty !== 1'b1 || o_count !== 4'd0) begin
         errors++;
         $display("FAIL single_empty: got empty=%b count=%0d, expected 1/0", o_empty, o_count);
      end
      tick();
      checks++;
      if (o_wr !== 1'b0 || wr_pulses != p + 1) begin
         errors++;
         $display("FAIL single_pulse: got wr=%b pulses=%0d, expected 0/%0d",
                  o_wr, wr_pulses - p, 1);
      end
   endtask

   task automatic test_in_order();
      int p;
      do_reset();
      alloc(5'd1, dval(5'd1), 0);
      alloc(5'd2, dval(5'd2), 1);
      alloc(5'd3, dval(5'd3), 2);
      p = wr_pulses;
      complete(2, dval(5'd3));
      tick();
      complete(1, dval(5'd2));
      tick();
      tick();
      checks++;
      if (wr_pulses != p || o_count !== 4'd3) begin
         errors++;
         $display("FAIL order_blocked: got pulses=%0d count=%0d, expected 0/3",
                  wr_pulses - p, o_count);
      end
      complete(0, dval(5'd1));
      for (int i = 1; i <= 3; i++) begin
         tick();
         checks++;
         if (o_wr !== 1'b1 || o_rd !== 5'(i)) begin
            errors++;
            $display("FAIL order_seq%0d: got wr=%b rd=%0d, expected 1/%0d", i, o_wr, o_rd, i);
         end
      end
      tick();
      checks++;
      if (o_wr !== 1'b0 || o_empty !== 1'b1) begin
         errors++;
         $display("FAIL order_end: got wr=%b empty=%b, expected 0/1", o_wr, o_empty);
      end
   endtask

   task automatic test_full();
      do_reset();
      i_alloc_valid = 1'b1;
      for (int i = 0; i < DEPTH; i++) begin
         i_alloc_rd = 5'(8 + i);
         exp_q.push_back('{5'(8 + i), dval(5'(8 + i))});
         tick();
      end
      checks++;
      if (o_full !== 1'b1 || o_alloc_ready !== 1'b0 || o_count !== 4'd8) begin
         errors++;
         $display("FAIL full_flags: got full=%b ready=%b count=%0d, expected 1/0/8",
                  o_full, o_alloc_ready, o_count);
      end
      i_alloc_rd = 5'd20;
      tick();
      checks++;
      if (o_count !== 4'd8 || o_alloc_tag !== 3'd0) begin
         errors++;
         $display("FAIL full_ignore: got count=%0d tag=%0d, expected 8/0", o_count, o_alloc_tag);
      end
      complete(0, dval(5'd8));
      i_alloc_valid = 1'b1;
      checks++;
      if (o_alloc_ready !== 1'b0) begin
         errors++;
         $display("FAIL full_commit_cycle_ready: got %b, expected 0", o_alloc_ready);
      end
      tick();
      checks++;
      if (o_alloc_ready !== 1'b1 || o_alloc_tag !== 3'd0 || o_count !== 4'd7) begin
         errors++;
         $display("FAIL full_reopen: got ready=%b tag=%0d count=%0d, expected 1/0/7",
                  o_alloc_ready, o_alloc_tag, o_count);
      end
      exp_q.push_back('{5'd20, dval(5'd20)});
      tick();
      i_alloc_valid = 1'b0;
      checks++;
      if (o_count !== 4'd8 || o_full !== 1'b1) begin
         errors++;
         $display("FAIL full_refill: got count=%0d full=%b, expected 8/1", o_count, o_full);
      end
      for (int t = 1; t < DEPTH; t++) complete(t, dval(5'(8 + t)));
      complete(0, dval(5'd20));
      wait_drain("full");
   endtask

   task automatic test_rd0();
      int p;
      do_reset();
      alloc(5'd0, 32'h0, 0);
      complete(0, 32'h1234_5678);
      p = wr_pulses;
      checks++;
      if (o_count !== 4'd1) begin
         errors++;
         $display("FAIL rd0_before: got count=%0d, expected 1", o_count);
      end
      tick();
      checks++;
      if (o_count !== 4'd0 || o_wr !== 1'b0 || o_alloc_tag !== 3'd1) begin
         errors++;
         $display("FAIL rd0_retire: got count=%0d wr=%b tag=%0d, expected 0/0/1",
                  o_count, o_wr, o_alloc_tag);
      end
      tick();
      checks++;
      if (wr_pulses != p) begin
         errors++;
         $display("FAIL rd0_nowrite: got pulses=%0d, expected 0", wr_pulses - p);
      end
   endtask

   task automatic test_back_to_back();
      do_reset();
      alloc(5'd3, 32'h0000_0033, 0);
      complete(0, 32'h0000_0033);
      // Commit of tag 0 and alloc of tag 1 share this edge
      i_alloc_valid = 1'b1;
      i_alloc_rd = 5'd4;
      exp_q.push_back('{5'd4, 32'h0000_0044});
      tick();
      i_alloc_valid = 1'b0;
      checks++;
      if (o_count !== 4'd1 || o_wr !== 1'b1) begin
         errors++;
         $display("FAIL b2b_count: got count=%0d wr=%b, expected 1/1", o_count, o_wr);
      end
      complete(1, 32'h0000_0044);
      // Already done: must be ignored
      complete(1, 32'h0BAD_0BAD);
      wait_drain("b2b");
   endtask

   task automatic test_flush();
      int p;
      do_reset();
      for (int i = 0; i < 4; i++) alloc(5'(i + 1), dval(5'(i + 1)), i);
      complete(1, dval(5'd2));
      complete(0, dval(5'd1));
      // Head is done: its commit is decided in the flush cycle and must be dropped
      i_flush = 1'b1;
      i_alloc_valid = 1'b1;
      i_alloc_rd = 5'd9;
      i_cmpl_valid = 1'b1;
      i_cmpl_tag = 3'd2;
      i_cmpl_data = 32'h1111_1111;
      exp_q.delete();
      p = wr_pulses;
      tick();
      i_flush = 1'b0;
      i_alloc_valid = 1'b0;
      i_cmpl_valid = 1'b0;
      checks++;
      if (o_count !== 4'd0 || o_wr !== 1'b0 || o_empty !== 1'b1 || o_alloc_ready !== 1'b1
          || o_alloc_tag !== 3'd0) begin
         errors++;
         $display("FAIL flush_state: got count=%0d wr=%b empty=%b ready=%b tag=%0d, %s",
                  o_count, o_wr, o_empty, o_alloc_ready, o_alloc_tag, "expected 0/0/1/1/0");
      end
      repeat (4) tick();
      checks++;
      if (wr_pulses != p) begin
         errors++;
         $display("FAIL flush_nowrite: got pulses=%0d, expected 0", wr_pulses - p);
      end
      alloc(5'd7, dval(5'd7), 0);
      complete(0, dval(5'd7));
      wait_drain("flush");
   endtask

   task automatic test_reset_mid();
      int p;
      do_reset();
      alloc(5'd9, dval(5'd9), 0);
      alloc(5'd10, dval(5'd10), 1);
      complete(0, dval(5'd9));
      rst = 1'b1;
      exp_q.delete();
      p = wr_pulses;
      tick();
      checks++;
      if (o_count !== 4'd0 || o_empty !== 1'b1 || o_full !== 1'b0 || o_alloc_ready !== 1'b1
          || o_alloc_tag !== 3'd0) begin
         errors++;
         $display("FAIL rstmid_occupancy: got count=%0d empty=%b full=%b ready=%b tag=%0d, %s",
                  o_count, o_empty, o_full, o_alloc_ready, o_alloc_tag,
                  "expected 0/1/0/1/0");
      end
      checks++;
      if (o_wr !== 1'b0 || o_rd !== 5'd0 || o_write_data !== 32'd0) begin
         errors++;
         $display("FAIL rstmid_wport: got wr=%b rd=%0d data=%h, expected 0/0/0",
                  o_wr, o_rd, o_write_data);
      end
      rst = 1'b0;
      tick();
      tick();
      checks++;
      if (o_wr !== 1'b0 || wr_pulses != p || o_count !== 4'd0) begin
         errors++;
         $display("FAIL rstmid_after: got wr=%b pulses=%0d count=%0d, expected 0/0/0",
                  o_wr, wr_pulses - p, o_count);
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_in_order();
      test_full();
      test_rd0();
      test_back_to_back();
      test_flush();
      test_reset_mid();
      tick();
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL final_pending: got %0d outstanding writes, expected 0", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
